// File: rtl/popcount_pkg.sv
// popcount_pkg: shared types and sizing helpers for the popcount sequencer.
package popcount_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam int CHUNK_W = 3;
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction
endpackage

// File: rtl/one_counter_v.sv
// one_counter_v: number of set bits in a 3-bit chunk.
module one_counter_v (
  input  logic [2:0] bits,
  output logic [1:0] count
);
  assign count = {1'b0, bits[0]} + {1'b0, bits[1]} + {1'b0, bits[2]};
endmodule

// File: rtl/popcount_sequencer.sv
// popcount_sequencer: streams a word 3 bits per cycle through one ones-count cell and accumulates the total.
module popcount_sequencer
  import popcount_pkg::*;
#(
  parameter int DATA_W = 24,
  localparam int NCHUNK = DATA_W / CHUNK_W,
  localparam int CNT_W = cnt_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);
  localparam int IDX_W = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (DATA_W <= 0 || DATA_W % CHUNK_W != 0) begin : g_bad_width
    $fatal(1, "DATA_W must be a positive multiple of 3");
  end
  state_t state, state_nxt;
  logic [DATA_W-1:0] sreg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] acc, sum;
  logic [1:0] cnt;
  logic last, accept;
  one_counter_v u_cnt (.bits(sreg[CHUNK_W-1:0]), .count(cnt));
  assign sum = acc + CNT_W'(cnt);
  assign last = idx == IDX_W'(NCHUNK - 1);
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // accept covers both IDLE and the HOLD handshake that chains straight into the next word
  always_comb
    state_nxt = flush ? IDLE
              : accept ? RUN
              : (state == RUN && last) ? HOLD
              : (state == HOLD && out_ready) ? IDLE
              : state;
  always_comb begin
    in_ready = !flush && (state == IDLE || (state == HOLD && out_ready));
    out_valid = state == HOLD;
    busy = state == RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sreg <= '0;
      idx <= '0;
      acc <= '0;
      out_count <= '0;
    end else if (flush) begin
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      sreg <= in_data;
      acc <= '0;
      idx <= '0;
    end else if (state == RUN) begin
      sreg <= sreg >> CHUNK_W;
      acc <= sum;
      idx <= idx + 1'b1;
      if (last) out_count <= sum;
    end
endmodule
